calc_rr_multiport: RTL
======================

Name: calc_rr_multiport

Overview:
- Parametrised successor to the 4-port calc1 calculator: NUM_PORTS request channels share one registered ALU.
- Each port captures two-cycle requests (command + operand1, then operand2) into a per-port FIFO with a caller-supplied tag.
- A round-robin arbiter issues one queued request per cycle.
- Each result returns on the originating port with its tag, so callers may keep several requests outstanding.

Parameters:
- NUM_PORTS, 4: number of request/response channels (1..8).
- DATA_W, 32: operand and result width.
- FIFO_DEPTH, 2: queued requests per port (power of 2, >=2).
- TAG_W, 2: width of the request tag echoed with each response.

Ports:
- c_clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_cmd_in  in  NUM_PORTS*4  per-port command; port p uses bits [4p+3:4p].
- req_data_in  in  NUM_PORTS*DATA_W  per-port operand bus.
- req_tag_in  in  NUM_PORTS*TAG_W  per-port tag, sampled on the command cycle only.
- out_busy  out  NUM_PORTS  port cannot accept a new command this cycle.
- out_resp  out  NUM_PORTS*2  response code: 0 none, 1 success, 2 error, 3 never driven.
- out_data  out  NUM_PORTS*DATA_W  result; 0 whenever the matching resp is not 1.
- out_tag  out  NUM_PORTS*TAG_W  tag of the returned request; 0 when resp=0.

Behaviour:
- Reset (async assert): all outputs 0; FIFOs emptied; capture FSMs to IDLE; execute stage invalid; arbiter pointer = NUM_PORTS-1, so port 0 has first priority. In-flight requests are discarded, with no response.
- Commands: 0 none, 1 add, 2 subtract, 5 shift left, 6 shift right. Any other non-zero value is invalid.
- Per-port capture FSM, IDLE/OP2:
  - IDLE: cmd!=0 and out_busy=0 at an edge latches cmd, data (op1) and tag; go to OP2.
  - IDLE: cmd!=0 with out_busy=1 is ignored entirely; no response is produced.
  - OP2: data is latched as op2 at the next edge regardless of cmd. The entry is pushed to the FIFO; return to IDLE.
  - OP2: cmd is don't-care; a non-zero cmd during OP2 is not treated as a new request.
- out_busy[p] is combinational from registered state: 1 when FIFO count==FIFO_DEPTH, or when count==FIFO_DEPTH-1 and the FSM is in OP2. This guarantees a push never meets a full FIFO.
- FIFO: push and pop in the same cycle are allowed; count is unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
- Arbiter:
  - Each cycle, grant the first non-empty FIFO searching from pointer+1, wrapping at NUM_PORTS.
  - Pop that FIFO into the execute register; pointer := granted port.
  - No grant leaves the pointer unchanged.
- Execute: one registered stage holding port id, cmd, op1, op2 and tag. The result is registered into that port's outputs at the next edge.
- Arithmetic, unsigned, DATA_W bits:
  - add: carry out of DATA_W bits gives resp 2, data 0; otherwise resp 1 with the sum.
  - subtract: op2>op1 (underflow) gives resp 2, data 0; otherwise resp 1 with op1-op2.
  - shifts: amount = op2[$clog2(DATA_W)-1:0], upper op2 bits ignored; logical shift, zero fill; resp 1.
  - invalid command: resp 2, data 0.
- Responses are one-cycle pulses. The next cycle the port returns to resp 0, data 0, tag 0, unless another result for that port lands back-to-back.
- Latency:
  - Command sampled at edge E0, op2 at E1 (FIFO write), pop/execute-load at E2 if granted, outputs valid after E3. Minimum latency is 3 edges.
  - Each additional cycle spent waiting for a grant adds one cycle.
- Ordering: results on any one port return in that port's issue order. Across ports, order follows arbitration.
- Reset asserted mid-request: a partially captured request or queued entry never produces a response after reset deasserts.

Test Plan:
- Reset, then port0 issues add 32'h1 + 32'h01FF_FFFF with tag 2 -> port0 resp=1, data=32'h0200_0000, tag=2, exactly 3 edges after the command edge; all other ports stay resp=0.
- All 4 ports issue in the same cycle: p0 add 5+3, p1 sub 3-5, p2 shl 1 by 31, p3 cmd 4 -> responses in order p0 resp 1 data 8, p1 resp 2 data 0, p2 resp 1 data 32'h8000_0000, p3 resp 2 data 0, on consecutive cycles E3..E6.
- Port1 issues add FFFF_FFFF+1, then immediately shr 32'hF0 by 32'h24 with tags 0 and 1 -> first resp 2 data 0 tag 0, then resp 1 data 32'h0F tag 1 (amount 4; upper op2 bits ignored).
- Back-to-back requests keep the arbiter saturated with other ports busy -> out_busy[p] rises when count reaches FIFO_DEPTH. A command presented while busy produces no response, and the total response count equals the number of accepted commands.
- Three ports continuously loaded -> grants rotate 0,1,2,0,1,2 with no port starved for more than NUM_PORTS-1 cycles.
- Reset pulse asserted while requests are queued on two ports -> outputs go to 0 immediately; no responses appear after deassert; a fresh add 2+2 then returns resp 1, data 4.

Source files
------------

// File: rtl/calc_rr_multiport.sv
// rtl/calc_rr_multiport.sv - multiport calculator sharing one registered ALU through a round-robin arbiter
//
// Each port captures a two-cycle request (cmd+op1+tag, then op2) into its own FIFO.
// A round-robin arbiter pops one queued request per cycle into a single execute
// register; the result is registered onto the originating port's outputs one edge later.
//
// Ports:
//   c_clk        clock, rising edge
//   reset        asynchronous active-high reset
//   req_cmd_in   per-port command, 4 bits each
//   req_data_in  per-port operand bus (op1 on command cycle, op2 on the next)
//   req_tag_in   per-port tag, sampled on the command cycle
//   out_busy     per-port: cannot accept a new command this cycle
//   out_resp     per-port response code (0 none, 1 success, 2 error)
//   out_data     per-port result, 0 unless resp is 1
//   out_tag      per-port tag of the returned request, 0 when resp is 0
module calc_rr_multiport #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = 2
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic [NUM_PORTS*4-1:0]      req_cmd_in,
    input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
    input  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in,
    output logic [NUM_PORTS-1:0]        out_busy,
    output logic [NUM_PORTS*2-1:0]      out_resp,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    output logic [NUM_PORTS*TAG_W-1:0]  out_tag
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(DATA_W);
    localparam int EW = 4 + 2 * DATA_W + TAG_W;

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    typedef enum logic {S_IDLE, S_OP2} cap_state_t;

    // FIFO entry layout: {cmd, op1, op2, tag}
    logic [EW-1:0]        head [NUM_PORTS];
    logic [NUM_PORTS-1:0] nonempty;
    logic [NUM_PORTS-1:0] pop;

    logic [PW-1:0] ptr;
    logic [PW-1:0] cand;
    logic [PW-1:0] grant_idx;
    logic          grant_valid;

    logic              ex_valid;
    logic [PW-1:0]     ex_port;
    logic [3:0]        ex_cmd;
    logic [DATA_W-1:0] ex_op1;
    logic [DATA_W-1:0] ex_op2;
    logic [TAG_W-1:0]  ex_tag;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        cap_state_t        state_q;
        cap_state_t        state_d;
        logic              capture;
        logic              push;
        logic [3:0]        cmd_q;
        logic [DATA_W-1:0] op1_q;
        logic [TAG_W-1:0]  tag_q;
        logic [AW-1:0]     wr_ptr;
        logic [AW-1:0]     rd_ptr;
        logic [AW:0]       count;
        logic [EW-1:0]     mem [FIFO_DEPTH];
        logic [3:0]        cmd;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;

        assign cmd  = req_cmd_in[4*p +: 4];
        assign data = req_data_in[DATA_W*p +: DATA_W];
        assign tag  = req_tag_in[TAG_W*p +: TAG_W];

        // Counting the in-progress capture as occupied means the push at the
        // end of OP2 always finds a free slot.
        assign out_busy[p] = (count == (AW+1)'(FIFO_DEPTH)) ||
                             ((count == (AW+1)'(FIFO_DEPTH - 1)) && (state_q == S_OP2));

        always_comb begin
            state_d = state_q;
            capture = 1'b0;
            push    = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd != 4'd0 && !out_busy[p]) begin
                        capture = 1'b1;
                        state_d = S_OP2;
                    end
                end
                S_OP2: begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        always_ff @(posedge c_clk or posedge reset) begin
            if (reset) begin
                state_q <= S_IDLE;
                cmd_q   <= '0;
                op1_q   <= '0;
                tag_q   <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
            end else begin
                state_q <= state_d;
                if (capture) begin
                    cmd_q <= cmd;
                    op1_q <= data;
                    tag_q <= tag;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop[p]) rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop[p]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        // Storage needs no reset: count gates every read.
        always_ff @(posedge c_clk) begin
            if (push) mem[wr_ptr] <= {cmd_q, op1_q, data, tag_q};
        end

        assign head[p]     = mem[rd_ptr];
        assign nonempty[p] = (count != '0);
        assign pop[p]      = grant_valid && (grant_idx == PW'(p));
    end

    // Search starts one past the last grant and wraps at NUM_PORTS.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        cand        = ptr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = (cand == PW'(NUM_PORTS - 1)) ? '0 : cand + 1'b1;
            if (!grant_valid && nonempty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            ptr      <= PW'(NUM_PORTS - 1);
            ex_valid <= 1'b0;
            ex_port  <= '0;
            ex_cmd   <= '0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_tag   <= '0;
        end else begin
            ex_valid <= grant_valid;
            if (grant_valid) begin
                ptr     <= grant_idx;
                ex_port <= grant_idx;
                {ex_cmd, ex_op1, ex_op2, ex_tag} <= head[grant_idx];
            end
        end
    end

    logic [DATA_W:0]   sum;
    logic [1:0]        res_code;
    logic [DATA_W-1:0] res_data;

    always_comb begin
        sum      = {1'b0, ex_op1} + {1'b0, ex_op2};
        res_code = RESP_ERR;
        res_data = '0;
        case (ex_cmd)
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    res_code = RESP_OK;
                    res_data = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (ex_op2 <= ex_op1) begin
                    res_code = RESP_OK;
                    res_data = ex_op1 - ex_op2;
                end
            end
            CMD_SHL: begin
                res_code = RESP_OK;
                res_data = ex_op1 << ex_op2[SW-1:0];
            end
            CMD_SHR: begin
                res_code = RESP_OK;
                res_data = ex_op1 >> ex_op2[SW-1:0];
            end
            default: begin
                res_code = RESP_ERR;
                res_data = '0;
            end
        endcase
    end

    // Every port not receiving a result this edge drops back to all-zero,
    // which makes responses single-cycle pulses.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (ex_valid && ex_port == PW'(p)) begin
                    out_resp[2*p +: 2]           <= res_code;
                    out_data[DATA_W*p +: DATA_W] <= res_data;
                    out_tag[TAG_W*p +: TAG_W]    <= ex_tag;
                end else begin
                    out_resp[2*p +: 2]           <= 2'd0;
                    out_data[DATA_W*p +: DATA_W] <= '0;
                    out_tag[TAG_W*p +: TAG_W]    <= '0;
                end
            end
        end
    end
endmodule
